// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the run-time instruction loader.
package instruction_loader_pkg;

    localparam int BYTES_PER_WORD   = 4;
    localparam int BYTE_COUNT_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready are both high;
// the source holds byte_data stable while byte_valid is high and the byte has not yet transferred.
interface instruction_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        write_enable;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        busy;
    logic        load_done;
    logic        checksum_error;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, write_enable, write_address, write_data,
               busy, load_done, checksum_error
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, write_enable, write_address, write_data,
               busy, load_done, checksum_error
    );
endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian 4-byte shift register with a wrapping byte counter.
module byte_packer
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [BYTE_COUNT_WIDTH-1:0] LAST_BYTE = BYTE_COUNT_WIDTH'(BYTES_PER_WORD - 1);

    logic [31:0]                 word_q, word_d;
    logic [BYTE_COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (clear) begin
            word_d  = '0;
            count_d = '0;
        end else if (byte_en) begin
            word_d  = {word_q[23:0], byte_in};
            count_d = count_q + 1'b1;
        end
    end

    // Pulses on the cycle the fourth byte is accepted, so the full word is in word_q next cycle.
    assign word_complete = byte_en && !clear && (count_q == LAST_BYTE);
    assign word          = word_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Packs a byte stream into 32-bit words and writes them to instruction memory from address 0.
// Optional trailing XOR checksum byte when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_loader_if.slave  bus,
    output state_e               state_dbg
);

    localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);

    state_e      state_q, state_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic        byte_ready_q, byte_ready_d;
    logic        write_enable_q, write_enable_d;
    logic        busy_q, busy_d;
    logic        load_done_q, load_done_d;
    logic        start_accept;
    logic        byte_accept;
    logic        word_complete;
    logic [31:0] packed_word;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic        checksum_error_q, checksum_error_d;
`endif

    assign byte_accept = (state_q == ST_LOAD) && bus.byte_valid && byte_ready_q;

    byte_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_accept),
        .byte_en       (byte_accept),
        .byte_in       (bus.byte_data),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        start_accept = 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum_d           = csum_q;
        checksum_error_d = checksum_error_q;
        if (byte_accept) csum_d = csum_q ^ bus.byte_data;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_LOAD;
                    word_idx_d   = '0;
                    start_accept = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    csum_d           = '0;
                    checksum_error_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (word_complete) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (word_idx_q == LAST_IDX) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    word_idx_d = word_idx_q + 32'd1;
                    state_d    = ST_LOAD;
                end
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.byte_valid && byte_ready_q) begin
                    checksum_error_d = (bus.byte_data != csum_q);
                    state_d          = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with the state they describe.
        byte_ready_d   = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        write_enable_d = (state_d == ST_WRITE);
        busy_d         = (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
        load_done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            word_idx_q     <= '0;
            byte_ready_q   <= 1'b0;
            write_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q           <= '0;
            checksum_error_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            byte_ready_q   <= byte_ready_d;
            write_enable_q <= write_enable_d;
            busy_q         <= busy_d;
            load_done_q    <= load_done_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q           <= csum_d;
            checksum_error_q <= checksum_error_d;
`endif
        end
    end

    assign bus.byte_ready    = byte_ready_q;
    assign bus.write_enable  = write_enable_q;
    assign bus.write_address = word_idx_q;
    assign bus.write_data    = packed_word;
    assign bus.busy          = busy_q;
    assign bus.load_done     = load_done_q;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    assign bus.checksum_error = checksum_error_q;
`else
    assign bus.checksum_error = 1'b0;
`endif
    assign state_dbg = state_q;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writes 32-bit MIPS instructions into the instruction memory that the fetch stage later reads by word-indexed `program_counter`. Accepts an 8-bit byte stream over a valid/ready handshake and packs four bytes, big-endian, into one instruction word. Issues one write per word at consecutive word addresses starting at 0, then flags completion. This lets the datapath be loaded at run time instead of only from a `.mem` file at elaboration.

## Interface
- `NUM_WORDS`, default 3: number of instruction words per load; range 1..2^32-1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  begins a load when sampled high in IDLE or DONE.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte, MSB of each word first.
- `byte_ready`  out  1  loader will accept a byte this cycle.
- `write_enable`  out  1  one-cycle memory write strobe.
- `write_address`  out  32  word index (0, 1, 2, …), same indexing as `program_counter`.
- `write_data`  out  32  assembled instruction.
- `busy`  out  1  high from start acceptance until DONE.
- `load_done`  out  1  high in DONE.
- `checksum_error`  out  1  checksum mismatch flag; constant 0 without the macro.

## Operation
- States: IDLE, LOAD, WRITE, CHECK (macro only), DONE.
- IDLE: `start` → LOAD. Word counter, byte counter, `write_address` and checksum accumulator clear to 0. `checksum_error` clears to 0.
- LOAD: `byte_ready`=1. A byte transfers on a cycle where `byte_valid && byte_ready`. The shift register updates as word = {word[23:0], byte_data}. The byte counter increments mod 4. On the 4th accepted byte → WRITE.
- WRITE: `write_enable`=1 for exactly one cycle, with `write_data` = packed word and `write_address` = current word index. `byte_ready`=0. Next state:
  - word index == NUM_WORDS-1 → CHECK (macro) or DONE;
  - otherwise, word index +1 → LOAD.
- DONE: `load_done`=1 and `busy`=0. `start` re-enters LOAD with all counters cleared, as from IDLE. Extra bytes are not accepted (`byte_ready`=0).
- `start` is ignored while `busy`.
- Address arithmetic is 32-bit unsigned, with no wrap within a load because word index < NUM_WORDS.
- `byte_valid` low stalls LOAD indefinitely; there is no timeout.

## Timing
- Reset values: `byte_ready`=0, `write_enable`=0, `write_address`=0, `write_data`=0, `busy`=0, `load_done`=0, `checksum_error`=0. State IDLE.
- `start` high at edge N → `busy` and `byte_ready` high after edge N.
- 4th byte accepted at edge M → `write_enable` high during cycle M..M+1. `byte_ready` returns high after edge M+1.
- Minimum 5 cycles per word. Full load without the macro takes ≥ 5·NUM_WORDS cycles after start.
- `write_address` and `write_data` are stable for the whole `write_enable` cycle. The memory captures on the edge that ends it.
- Reset mid-load: outputs go to reset values asynchronously and the partial word is discarded. Words already written stay in memory.

## Configuration
- `INSTRUCTION_LOADER_CHECKSUM_EN` defined:
  - an 8-bit XOR accumulator covers every accepted data byte;
  - after the last WRITE, the FSM enters CHECK with `byte_ready`=1 and accepts one more byte;
  - `checksum_error` is set to (byte != accumulator);
  - then DONE; `checksum_error` holds until the next start or reset.
- Not defined: no CHECK state, no accumulator, `checksum_error` tied 0, and WRITE of the last word goes directly to DONE.

## Structure
- Package `instruction_loader_pkg`: state enum, `BYTES_PER_WORD`=4, `BYTE_COUNT_WIDTH`=2.
- Sub-module `byte_packer`: 4-byte shift register plus byte counter. Outputs are `word` and `word_complete`; it is cleared by a `clear` input from the FSM.
- The top level holds the FSM, word counter, and checksum logic.

## Test plan
- Reset then NUM_WORDS=3; stream 8C 01 00 04, 20 42 00 01, AC 03 00 08 back-to-back → three writes: addr 0 = 32'h8C010004, addr 1 = 32'h20420001, addr 2 = 32'hAC030008; `load_done`=1 at cycle 15 after start.
- Same data with `byte_valid` toggled every other cycle → identical writes, only later; `byte_ready` never drops in LOAD.
- Assert `reset` after the 2nd byte of word 1 → all outputs 0 at once. Restart → word 0 written again at addr 0 with the new data.
- `start` pulsed during LOAD → no effect: counters unchanged and no extra write.
- Macro on: bytes of words 0..2 as above, then checksum byte = XOR of all 12 bytes → `checksum_error`=0. Repeat with the checksum byte inverted → `checksum_error`=1 and `load_done`=1.
- From DONE, `start` again → `write_address` restarts at 0 and `load_done` drops the next cycle.
